// File: rtl/soc_addr_map_responder.sv
`default_nettype none
// ============================================================================
// Module   : soc_addr_map_responder
// Brief    : AXI-Lite read-only responder exposing the SoC address map
//            (rule count, ID word, base/length per crossbar slave index).
// Revision : 1.0 - initial release
// ============================================================================
module soc_addr_map_responder #(
    parameter int unsigned                  NUM_RULES   = 13,
    parameter logic [NUM_RULES-1:0][63:0]   RULE_BASE   = '0,
    parameter logic [NUM_RULES-1:0][63:0]   RULE_LENGTH = '0,
    parameter logic [31:0]                  ID_CODE     = 32'h20001001,
    parameter int unsigned                  ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // write address channel
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    // write data channel
    input  logic [63:0]           wdata_i,
    input  logic [7:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    // write response channel
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    // read address channel
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    // read data channel
    output logic [63:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i
);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;
    localparam logic [7:0] c_num_rules   = 8'(NUM_RULES);

    // Maps a 12-bit window offset to {resp, data}. Misalignment wins over
    // decode; table entries start at 0x100 with a 16-byte stride, base in
    // the low doubleword and length in the high doubleword.
    function automatic logic [65:0] f_decode(input logic [11:0] off);
        logic [7:0]  idx;
        logic [65:0] res;
        res = {c_resp_decerr, 64'h0};
        idx = off[11:4] - 8'd16;
        if (off[2:0] != 3'b000) begin
            res = {c_resp_slverr, 64'h0};
        end else if (off == 12'h000) begin
            res = {c_resp_okay, 64'(NUM_RULES)};
        end else if (off == 12'h008) begin
            res = {c_resp_okay, 32'h0, ID_CODE};
        end else if ((off[11:8] != 4'h0) && (idx < c_num_rules)) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                if (idx == 8'(i)) begin
                    res = {c_resp_okay, (off[3] ? RULE_LENGTH[i] : RULE_BASE[i])};
                end
            end
        end
        return res;
    endfunction

    // Only the 4 KiB window offset is decoded; write payload is discarded.
    logic w_unused;
    assign w_unused = ^{awaddr_i[ADDR_WIDTH-1:12], araddr_i[ADDR_WIDTH-1:12],
                        wdata_i, wstrb_i};

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    r_state_e    r_rd_state;
    r_state_e    w_rd_state_next;
    logic        w_rd_capture;
    logic [63:0] r_rdata;
    logic [1:0]  r_rresp;

    // Read FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    // Read FSM next-state and capture strobe
    always_comb begin
        w_rd_state_next = r_rd_state;
        w_rd_capture    = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (arvalid_i) begin
                    w_rd_capture    = 1'b1;
                    w_rd_state_next = R_RESP;
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    w_rd_state_next = R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    // Read data/response register, loaded only on AR acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= 64'h0;
            r_rresp <= c_resp_okay;
        end else if (w_rd_capture) begin
            {r_rresp, r_rdata} <= f_decode(araddr_i[11:0]);
        end
    end

    assign arready_o = (r_rd_state == R_IDLE);
    assign rvalid_o  = (r_rd_state == R_RESP);
    assign rdata_o   = r_rdata;
    assign rresp_o   = r_rresp;

    // ------------------------------------------------------------------
    // Write path: the table is read-only, so every write is answered with
    // an error; only the AW offset decides which error.
    // ------------------------------------------------------------------
    logic        r_aw_held;
    logic        r_w_held;
    logic [11:0] r_aw_off;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_held_next;
    logic        w_w_held_next;
    logic [11:0] w_aw_off;
    logic [65:0] w_aw_dec;
    logic [1:0]  w_bresp_next;

    assign awready_o = !r_aw_held && !r_bvalid;
    assign wready_o  = !r_w_held  && !r_bvalid;
    assign w_aw_hs   = awvalid_i && awready_o;
    assign w_w_hs    = wvalid_i  && wready_o;

    // Looking at the post-handshake flags lets B issue the cycle after the
    // later of the two handshakes rather than one cycle later.
    assign w_aw_held_next = r_aw_held || w_aw_hs;
    assign w_w_held_next  = r_w_held  || w_w_hs;
    assign w_aw_off       = w_aw_hs ? awaddr_i[11:0] : r_aw_off;
    assign w_aw_dec       = f_decode(w_aw_off);
    assign w_bresp_next   = (w_aw_dec[65:64] == c_resp_decerr) ? c_resp_decerr
                                                               : c_resp_slverr;

    // Write holding flags and B response generation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_off  <= 12'h0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
        end else if (r_bvalid) begin
            if (bready_i) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end else begin
            r_aw_held <= w_aw_held_next;
            r_w_held  <= w_w_held_next;
            if (w_aw_hs) begin
                r_aw_off <= awaddr_i[11:0];
            end
            if (w_aw_held_next && w_w_held_next) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_bresp_next;
            end
        end
    end

    assign bvalid_o = r_bvalid;
    assign bresp_o  = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_soc_addr_map_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_addr_map_responder
// Brief    : Self-checking bench for soc_addr_map_responder: directed cases
//            plus randomized reads/writes against an arithmetic map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_addr_map_responder;

    localparam int          N_RULES = 13;
    localparam logic [31:0] ID_WORD = 32'h20001001;

    // Reference table contents, computed per slave index.
    function automatic logic [63:0] ref_base(input int i);
        if (i == 12)     return 64'h8000_0000;
        else if (i == 5) return 64'h1C00_0000;
        else             return 64'h0000_0040_0000_0000 + 64'(i) * 64'h0100_0000;
    endfunction

    function automatic logic [63:0] ref_len(input int i);
        if (i == 12) return 64'h2000_0000;
        else         return 64'h1000 << i;
    endfunction

    function automatic logic [N_RULES-1:0][63:0] pack_bases();
        logic [N_RULES-1:0][63:0] v;
        for (int i = 0; i < N_RULES; i++) v[i] = ref_base(i);
        return v;
    endfunction

    function automatic logic [N_RULES-1:0][63:0] pack_lens();
        logic [N_RULES-1:0][63:0] v;
        for (int i = 0; i < N_RULES; i++) v[i] = ref_len(i);
        return v;
    endfunction

    localparam logic [N_RULES-1:0][63:0] c_bases = pack_bases();
    localparam logic [N_RULES-1:0][63:0] c_lens  = pack_lens();

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_addr_map_responder #(
        .NUM_RULES  (N_RULES),
        .RULE_BASE  (c_bases),
        .RULE_LENGTH(c_lens),
        .ID_CODE    (ID_WORD),
        .ADDR_WIDTH (32)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .awaddr_i (awaddr),
        .awvalid_i(awvalid),
        .awready_o(awready),
        .wdata_i  (wdata),
        .wstrb_i  (wstrb),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .bresp_o  (bresp),
        .bvalid_o (bvalid),
        .bready_i (bready),
        .araddr_i (araddr),
        .arvalid_i(arvalid),
        .arready_o(arready),
        .rdata_o  (rdata),
        .rresp_o  (rresp),
        .rvalid_o (rvalid),
        .rready_i (rready)
    );

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Address-map model: plain arithmetic on the byte offset.
    function automatic void ref_read(input logic [11:0] off, output logic [1:0] resp,
                                     output logic [63:0] data);
        int o;
        o    = int'(off);
        resp = 2'b11;
        data = 64'h0;
        if (o % 8 != 0) begin
            resp = 2'b10;
        end else if (o == 0) begin
            resp = 2'b00; data = 64'(N_RULES);
        end else if (o == 8) begin
            resp = 2'b00; data = {32'h0, ID_WORD};
        end else if (o >= 256 && (o - 256) / 16 < N_RULES) begin
            resp = 2'b00;
            data = ((o - 256) % 16 == 0) ? ref_base((o - 256) / 16)
                                         : ref_len((o - 256) / 16);
        end
    endfunction

    function automatic logic [1:0] ref_write(input logic [11:0] off);
        logic [1:0]  r;
        logic [63:0] d;
        ref_read(off, r, d);
        return (r == 2'b11) ? 2'b11 : 2'b10;
    endfunction

    // One read; stall = cycles rready is held low once rvalid is up.
    // With chain_ar a second AR to 0x008 is presented during the stall.
    task automatic do_read(input logic [31:0] addr, input int stall,
                           input bit chain_ar, input string tag);
        logic [1:0]  er;
        logic [63:0] ed;
        logic        hs;
        ref_read(addr[11:0], er, ed);
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (stall == 0);
        hs      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            hs = arready;
            @(posedge clk); #1;
            if (hs) break;
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (!hs) check_value({tag, "_ar_timeout"}, 64'(hs), 64'd1);
        check_value({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check_value({tag, "_rresp"},  64'(er === rresp ? er : rresp), 64'(er));
        check_value({tag, "_rdata"},  rdata, ed);
        if (chain_ar) begin
            araddr  = 32'h0000_0008;
            arvalid = 1'b1;
        end
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check_value({tag, "_stall_rvalid"},  64'(rvalid),  64'd1);
            check_value({tag, "_stall_rdata"},   rdata,        ed);
            check_value({tag, "_stall_arready"}, 64'(arready), 64'd0);
        end
        if (stall != 0) begin
            @(negedge clk);
            rready = 1'b1;
        end
        @(posedge clk); #1;
        check_value({tag, "_rvalid_done"}, 64'(rvalid), 64'd0);
        if (chain_ar) begin
            check_value({tag, "_arready_after"}, 64'(arready), 64'd1);
            @(posedge clk); #1;
            arvalid = 1'b0;
            check_value({tag, "_chain_rvalid"}, 64'(rvalid), 64'd1);
            check_value({tag, "_chain_rdata"},  rdata, {32'h0, ID_WORD});
            @(posedge clk); #1;
            check_value({tag, "_chain_done"}, 64'(rvalid), 64'd0);
        end
        rready = 1'b0;
    endtask

    // One write; AW and W are raised after aw_d / w_d cycles respectively.
    task automatic do_write(input logic [31:0] addr, input int aw_d, input int w_d,
                            input string tag);
        logic [1:0] eb;
        bit aw_done, w_done, aw_hs, w_hs;
        eb      = ref_write(addr[11:0]);
        aw_done = 0;
        w_done  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!aw_done && c >= aw_d) begin awaddr = addr; awvalid = 1'b1; end
            if (!w_done && c >= w_d) begin
                wdata = {$urandom, $urandom}; wstrb = 8'hFF; wvalid = 1'b1;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
            if (aw_done && w_done) break;
            if (w_done)  check_value({tag, "_wready_held"},  64'(wready),  64'd0);
            if (aw_done) check_value({tag, "_awready_held"}, 64'(awready), 64'd0);
            check_value({tag, "_bvalid_early"}, 64'(bvalid), 64'd0);
        end
        if (!(aw_done && w_done)) check_value({tag, "_hs_timeout"}, 64'd0, 64'd1);
        check_value({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        check_value({tag, "_bresp"},  64'(bresp),  64'(eb));
        @(posedge clk); #1;
        check_value({tag, "_bresp_hold"}, 64'(bresp), 64'(eb));
        check_value({tag, "_awready_b"},  64'(awready), 64'd0);
        @(negedge clk);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_value({tag, "_bvalid_done"}, 64'(bvalid), 64'd0);
        check_value({tag, "_awready_done"}, 64'(awready), 64'd1);
        check_value({tag, "_wready_done"},  64'(wready),  64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_arready"}, 64'(arready), 64'd1);
        check_value({tag, "_awready"}, 64'(awready), 64'd1);
        check_value({tag, "_wready"},  64'(wready),  64'd1);
        check_value({tag, "_rvalid"},  64'(rvalid),  64'd0);
        check_value({tag, "_bvalid"},  64'(bvalid),  64'd0);
        check_value({tag, "_rdata"},   rdata,        64'd0);
        check_value({tag, "_rresp"},   64'(rresp),   64'd0);
        check_value({tag, "_bresp"},   64'(bresp),   64'd0);
    endtask

    initial begin
        logic [11:0] off;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 check_reset_values("post_rst");

        // Identification and table reads
        do_read(32'h000, 0, 0, "rd_num");
        do_read(32'h008, 0, 0, "rd_id");
        do_read(32'h1C0, 0, 0, "rd_base12");
        do_read(32'h1C8, 0, 0, "rd_len12");
        do_read(32'h150, 0, 0, "rd_base5");
        // Boundary and error responses
        do_read(32'h1D0, 0, 0, "rd_past_end");
        do_read(32'h010, 0, 0, "rd_hole");
        do_read(32'h104, 0, 0, "rd_misalign");
        do_read(32'hFFFF_F100, 0, 0, "rd_upper_bits");
        // Backpressure with a queued second AR
        do_read(32'h100, 5, 1, "rd_stall");

        // Writes are refused; table unchanged afterwards
        do_write(32'h100, 3, 0, "wr_w_first");
        do_read(32'h100, 0, 0, "rd_after_wr");
        do_write(32'h800, 0, 0, "wr_decerr");
        do_write(32'h1C8, 0, 2, "wr_aw_first");

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: off = 12'(32'h100 + 16 * $urandom_range(0, 14) + 8 * $urandom_range(0, 1));
                1: off = 12'($urandom);
                2: off = 12'(8 * $urandom_range(0, 1));
                default: off = 12'($urandom) & 12'hFF8;
            endcase
            do_read({20'($urandom), off}, int'($urandom_range(0, 2)), 0, "rnd_rd");
        end
        for (int n = 0; n < 12; n++) begin
            off = 12'($urandom) & 12'hFF8;
            if (n % 3 == 0) off = 12'(32'h100 + 16 * $urandom_range(0, 14));
            do_write({20'($urandom), off}, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), "rnd_wr");
        end

        // Reset with both an R and a B response pending
        @(negedge clk);
        araddr = 32'h1C0; arvalid = 1'b1;
        awaddr = 32'h100; awvalid = 1'b1;
        wvalid = 1'b1;    rready  = 1'b0; bready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check_value("pend_rvalid", 64'(rvalid), 64'd1);
        check_value("pend_bvalid", 64'(bvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        rready = 1'b1;
        bready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_value("stale_rvalid", 64'(rvalid), 64'd0);
            check_value("stale_bvalid", 64'(bvalid), 64'd0);
        end
        rready = 1'b0;
        bready = 1'b0;
        do_read(32'h008, 0, 0, "rd_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_addr_map_responder.md
# soc_addr_map_responder

AXI-Lite responder that lets software and the debug module discover the SoC address map at runtime. It holds a read-only table of the base address and length of every crossbar slave, plus a rule count and an ID word, and returns them on AXI-Lite reads. It sits behind the AXILiteDom peripheral port. It is the reader-side counterpart of the crossbar's address-decode rules: the crossbar maps address to slave index, and this block maps slave index back to its address window.

## Interface
Parameters:
- NumRules, 13: number of map entries (slave indices 0..NumRules-1); legal range 1..240.
- RuleBase, '0: array [NumRules] of 64-bit base addresses, indexed by slave index.
- RuleLength, '0: array [NumRules] of 64-bit region lengths.
- IdCode, 32'h20001001: value returned in the ID register, zero-extended to 64 bits.
- AddrWidth, 32: AXI-Lite address width. Only bits [11:0] are decoded; the window is 4 KiB.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- awaddr_i  in  AddrWidth  write address.
- awvalid_i  in  1;  awready_o  out  1.
- wdata_i  in  64;  wstrb_i  in  8;  wvalid_i  in  1;  wready_o  out  1.
- bresp_o  out  2;  bvalid_o  out  1;  bready_i  in  1.
- araddr_i  in  AddrWidth  read address.
- arvalid_i  in  1;  arready_o  out  1.
- rdata_o  out  64;  rresp_o  out  2;  rvalid_o  out  1;  rready_i  in  1.

## Operation
Register map (offset = addr[11:0]):
- 0x000: NumRules.
- 0x008: IdCode.
- 0x100 + 16*i: RuleBase[i], for i < NumRules.
- 0x108 + 16*i: RuleLength[i], for i < NumRules.
- Any other 8-byte-aligned offset: DECERR (2'b11), rdata 0.
- Offset with addr[2:0] != 0: SLVERR (2'b10), rdata 0. The alignment check takes priority over the decode check.

Read FSM, states R_IDLE and R_RESP:
- R_IDLE: arready_o = 1. When arvalid_i is high, register rdata and rresp, then go to R_RESP.
- R_RESP: rvalid_o = 1 and arready_o = 0. When rready_i is high, go to R_IDLE.
- At most one read is outstanding at a time.

Write path (table is read-only):
- AW and W are captured independently into separate holding flags. awready_o = !aw_held and wready_o = !w_held, both forced low while bvalid_o is high.
- Once both flags are set, assert bvalid_o with the following response:
  - DECERR if the AW offset is undecodable.
  - SLVERR otherwise, including misaligned offsets.
- On bready_i high, clear bvalid_o and both flags.
- Table contents never change. wdata_i and wstrb_i are ignored.

The read and write paths are fully independent; concurrent traffic on both paths is legal.

## Timing
- Reset values: arready_o = 1, awready_o = 1, wready_o = 1, rvalid_o = 0, bvalid_o = 0, rdata_o = 0, rresp_o = 0, bresp_o = 0. Both FSMs are in idle with the holding flags clear.
- Read latency: AR handshake in cycle N gives rvalid_o in cycle N+1.
- rdata_o and rresp_o are registered and stay stable while rvalid_o is high and rready_i is low.
- Back-to-back reads: the next AR can be accepted in the cycle after the R handshake, so the peak rate is one read every 2 cycles.
- Write latency: when the later of the AW and W handshakes completes in cycle N, bvalid_o asserts in cycle N+1.
- AW and W in the same cycle are both accepted in that cycle.
- bresp_o is stable while bvalid_o is high.
- Valid signals never deassert without a handshake, except on reset.
- Reset asserted mid-transaction aborts it: the block returns immediately (asynchronously) to the reset values, and no response is issued afterwards.
- No combinational path from any input to any valid or data output. The ready outputs depend only on state.

## Test plan
Use NumRules = 13, with RuleBase[12] = 64'h8000_0000, RuleLength[12] = 64'h2000_0000 and RuleBase[5] = 64'h1C00_0000.
- Read 0x000 then 0x008, with rready held high: rdata = 13 then 64'h20001001, rresp = OKAY, each rvalid one cycle after its AR.
- Read 0x1C0, 0x1C8 and 0x150: 64'h8000_0000, 64'h2000_0000 and 64'h1C00_0000, all OKAY.
- Read 0x1D0 (i = 13), 0x010 and 0x104: DECERR with rdata 0 for the first two; SLVERR with rdata 0 for 0x104.
- Read 0x100 with rready low for 5 cycles: rvalid stays high, rdata stays at RuleBase[0], arready stays low, and a second arvalid is not accepted until the cycle after the R handshake.
- Write to 0x100 with W sent 3 cycles before AW: wready drops after the W handshake; bvalid rises one cycle after the AW handshake with SLVERR; a subsequent read of 0x100 returns the unchanged value. Write to 0x800: DECERR.
- Assert reset while rvalid and bvalid are both pending: all outputs return to the reset values, and after release no stale R or B response appears.
